lsu_wb: RTL and testbench
=========================

Name: lsu_wb

Overview:
Parametrised successor to the EX→MEM→WB glue stage. It owns the data-memory access and the GPR write-back.
- Non-memory results pass straight through to the GPR write port.
- Loads and stores run a valid/ready transaction against data memory and stall the pipeline for the whole access.
- Adds sub-word load/store alignment with sign/zero extension, XLEN 32/64 support, misalignment detection and a bus timeout.
- Sits between the EX stage, the data memory port, `gprs` and `cpu_ctrl`. `stall` is combinational to `cpu_ctrl`.

Parameters:
- XLEN, 32, data/address width. Legal values are 32 and 64.
- REG_AW, 5, GPR address width.
- TIMEOUT, 16, cycles allowed in REQ or WAIT before the access is aborted. Must be ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-low.
- ex_valid  in  1  EX holds a valid instruction
- ex_mem_ena  in  1  instruction accesses memory (`ENABLE`/`DISABLE`)
- ex_mem_rw  in  1  `MEM_READ` or `MEM_WRITE`
- ex_funct3  in  3  RISC-V load/store funct3
- ex_addr  in  XLEN  effective address
- ex_store_data  in  XLEN  rs2 value, right-aligned
- gprs_waddr_i  in  REG_AW  destination register
- gprs_wdata_i  in  XLEN  ALU result
- mem_req  out  1  request valid
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  address, lane-aligned (low log2(XLEN/8) bits zero)
- mem_wdata  out  XLEN  store data shifted into its lanes
- mem_wstrb  out  XLEN/8  byte enables
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data, full lane word
- gprs_waddr_o  out  REG_AW  write address (`REG_X0` = no write)
- gprs_wdata_o  out  XLEN  write data
- misalign  out  1  one-cycle pulse: misaligned or illegal-size access
- bus_err  out  1  one-cycle pulse: timeout abort
- stall  out  1  combinational stall request to `cpu_ctrl`

Behaviour:
- FSM states: IDLE, REQ, WAIT, WB.
- Reset (asynchronous, active-low):
  - state = IDLE; counter = 0.
  - mem_req, mem_we, mem_wstrb, misalign, bus_err = 0.
  - stall forced to 0; gprs_waddr_o = `REG_X0`; gprs_wdata_o = `DATA_ZERO`.
  - A reset asserted during REQ or WAIT drops mem_req immediately. No write-back occurs.
- Size legality:
  - funct3 011 (LD/SD) and 110 (LWU) are illegal when XLEN=32.
  - 1xx stores are always illegal.
- Alignment rules:
  - Halfword: addr[0]=0.
  - Word: addr[1:0]=0.
  - Double: addr[2:0]=0.
- IDLE:
  - ex_valid & !ex_mem_ena: gprs_waddr_o/gprs_wdata_o = gprs_waddr_i/gprs_wdata_i in the same cycle. stall = 0.
  - ex_valid & ex_mem_ena & illegal or misaligned: misalign = 1 for this cycle. No request. Write `REG_X0`. stall = 0. Stay in IDLE.
  - ex_valid & ex_mem_ena & legal:
    - stall = 1 combinationally.
    - Latch addr, funct3, rd, rw and the shifted store data/strobes.
    - Go to REQ.
  - Otherwise: write `REG_X0`/`DATA_ZERO`.
- REQ:
  - mem_req = 1. Request fields are driven from the latched registers and held stable until mem_ready.
  - stall = 1.
  - On mem_ready: a load goes to WAIT; a store goes to WB.
- WAIT:
  - stall = 1. mem_req = 0.
  - On mem_rvalid: extract and extend the data into the result register. Go to WB.
- Counter:
  - Clears on entry to REQ and to WAIT.
  - Increments each cycle spent in REQ or WAIT.
  - On reaching TIMEOUT (ready or rvalid still absent): bus_err = 1 for one cycle, drop mem_req, result register = `REG_X0`, go to WB.
- WB:
  - stall = 0. The pipeline advances at the end of this cycle.
  - Load: gprs_waddr_o = latched rd; gprs_wdata_o = extended data.
  - Store or aborted access: `REG_X0`.
  - ex_valid is ignored in WB, because EX still holds the same instruction. Always return to IDLE.
- Load extraction:
  - lane = addr[log2(XLEN/8)-1:0]; field = mem_rdata >> (8·lane).
  - LB/LH/LW: sign-extend. LBU/LHU/LWU: zero-extend. LD: no extension.
- Store:
  - mem_wdata = ex_store_data << (8·lane).
  - mem_wstrb = ((1 << bytes) − 1) << lane.
- Latency: minimum load stall is 3 cycles (IDLE, REQ with immediate ready, WAIT with rvalid); WB follows. Minimum store stall is 2 cycles.
- A load with rd = x0 still performs the memory access and writes back to x0.

Decomposition:
- `common.v` gains:
  - funct3 encodings (`LB`…`LWU`, `SB`…`SD`)
  - FSM state encodings
  - `MEM_READ`/`MEM_WRITE`
- `REG_BUS`, `DATA_BUS`, `REG_X0` and `DATA_ZERO` already live there.
- One sub-module: `lsu_align`. It is combinational. It provides:
  - store shift and strobe generation
  - load extract and extension
  - legality/alignment check
- All sequential logic stays in `lsu_wb`.

Test Plan:
1. ALU pass-through: ex_valid=1, mem_ena=0, waddr=5, wdata=0x1234 → same cycle gprs_waddr_o=5, gprs_wdata_o=0x1234, stall=0, mem_req=0.
2. LB at 0x103, ready immediate, rvalid next cycle with rdata=0x80FF0000 → stall high 3 cycles, mem_addr=0x100, WB writes 0xFFFFFF80 to rd.
3. LHU at 0x102, rdata=0xBEEF1234 → WB writes 0x0000BEEF. A back-to-back second load starts in the cycle after WB, not during WB.
4. SH at 0x102 with data 0x0000ABCD, ready delayed 3 cycles → mem_req held with stable fields, mem_wdata=0xABCD0000, mem_wstrb=4'b1100, no GPR write.
5. LW at 0x101 and LD at 0x100 (XLEN=32) → each pulses misalign for 1 cycle; mem_req=0, stall=0, gprs_waddr_o=x0.
6. Abort and reset (TIMEOUT=8):
   - rvalid never arrives → bus_err after 8 WAIT cycles, WB writes x0, stall drops.
   - Separately, rst asserted mid-REQ → mem_req=0 and stall=0 before the next clock edge.

Source files
------------

// File: rtl/lsu_wb_pkg.sv
// Shared encodings for the load/store + write-back stage: funct3 sizes,
// access direction, enable flag and the access FSM states.
package lsu_wb_pkg;

  // Load funct3
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store funct3
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/strobes, load extract/extend and
// the size/alignment legality check for the access presented by EX.
module lsu_align
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                         rw,
  input  logic [2:0]                   funct3,
  input  logic [2:0]                   addr_lo,
  input  logic [XLEN-1:0]              store_data,
  output logic                         ok,
  output logic [XLEN-1:0]              wdata,
  output logic [XLEN/8-1:0]            wstrb,
  input  logic [2:0]                   ld_funct3,
  input  logic [$clog2(XLEN/8)-1:0]    ld_lane,
  input  logic [XLEN-1:0]              rdata,
  output logic [XLEN-1:0]              ld_data
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);

  logic [LANE_W-1:0] lane;
  logic              size_ok;
  logic              align_ok;
  logic [7:0]        mask8;
  logic [XLEN-1:0]   field;

  always_comb begin
    lane    = addr_lo[LANE_W-1:0];
    size_ok = 1'b1;
    if (funct3 == 3'b111)                       size_ok = 1'b0;
    if (rw == MEM_WRITE && funct3[2])           size_ok = 1'b0;
    if (XLEN == 32 && (funct3 == LD || funct3 == LWU)) size_ok = 1'b0;

    case (funct3[1:0])
      2'b00:   begin align_ok = 1'b1;                mask8 = 8'h01; end
      2'b01:   begin align_ok = ~addr_lo[0];         mask8 = 8'h03; end
      2'b10:   begin align_ok = (addr_lo[1:0] == 2'b00); mask8 = 8'h0F; end
      default: begin align_ok = (addr_lo == 3'b000); mask8 = 8'hFF; end
    endcase
    ok = size_ok & align_ok;

    wdata = store_data << {lane, 3'b000};
    // Oversized masks only arise for accesses already flagged illegal.
    wstrb = NB'(mask8) << lane;
  end

  always_comb begin
    field = rdata >> {ld_lane, 3'b000};
    case (ld_funct3)
      LB:      ld_data = XLEN'($signed(field[7:0]));
      LH:      ld_data = XLEN'($signed(field[15:0]));
      LW:      ld_data = XLEN'($signed(field[31:0]));
      LBU:     ld_data = XLEN'(field[7:0]);
      LHU:     ld_data = XLEN'(field[15:0]);
      LWU:     ld_data = XLEN'(field[31:0]);
      default: ld_data = field;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// EX->MEM->WB stage: ALU results pass straight to the GPR port, loads and
// stores run a valid/ready access against data memory while stalling.
module lsu_wb
  import lsu_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_mem_ena,
  input  logic                ex_mem_rw,
  input  logic [2:0]          ex_funct3,
  input  logic [XLEN-1:0]     ex_addr,
  input  logic [XLEN-1:0]     ex_store_data,
  input  logic [REG_AW-1:0]   gprs_waddr_i,
  input  logic [XLEN-1:0]     gprs_wdata_i,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic [REG_AW-1:0]   gprs_waddr_o,
  output logic [XLEN-1:0]     gprs_wdata_o,
  output logic                misalign,
  output logic                bus_err,
  output logic                stall
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);
  localparam logic [REG_AW-1:0] REG_X0    = '0;
  localparam logic [XLEN-1:0]   DATA_ZERO = '0;

  lsu_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   lat_addr;
  logic [2:0]        lat_f3;
  logic [REG_AW-1:0] lat_rd;
  logic              lat_rw;
  logic [XLEN-1:0]   lat_wdata;
  logic [NB-1:0]     lat_wstrb;
  logic [REG_AW-1:0] res_rd;
  logic [XLEN-1:0]   res_data;

  logic              al_ok;
  logic [XLEN-1:0]   al_wdata;
  logic [NB-1:0]     al_wstrb;
  logic [XLEN-1:0]   al_ld_data;

  logic start, cnt_clr, cnt_inc, res_load, res_x0, timeout;

  lsu_align #(.XLEN(XLEN)) u_align (
    .rw         (ex_mem_rw),
    .funct3     (ex_funct3),
    .addr_lo    (ex_addr[2:0]),
    .store_data (ex_store_data),
    .ok         (al_ok),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .ld_funct3  (lat_f3),
    .ld_lane    (lat_addr[LANE_W-1:0]),
    .rdata      (mem_rdata),
    .ld_data    (al_ld_data)
  );

  assign mem_addr  = {lat_addr[XLEN-1:LANE_W], {LANE_W{1'b0}}};
  assign mem_wdata = lat_wdata;
  assign mem_we    = mem_req & lat_rw;
  assign mem_wstrb = mem_req ? lat_wstrb : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    stall        = 1'b0;
    misalign     = 1'b0;
    bus_err      = 1'b0;
    gprs_waddr_o = REG_X0;
    gprs_wdata_o = DATA_ZERO;
    start        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    res_load     = 1'b0;
    res_x0       = 1'b0;
    timeout      = (cnt == CNT_MAX);

    case (state)
      IDLE: begin
        if (ex_valid && ex_mem_ena != ENABLE) begin
          gprs_waddr_o = gprs_waddr_i;
          gprs_wdata_o = gprs_wdata_i;
        end else if (ex_valid) begin
          if (!al_ok) misalign = 1'b1;
          else begin
            stall     = 1'b1;
            start     = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (timeout) begin
          bus_err   = 1'b1;
          res_x0    = 1'b1;
          state_nxt = WB;
        end else begin
          mem_req = 1'b1;
          if (!mem_ready) cnt_inc = 1'b1;
          else if (lat_rw == MEM_READ) begin
            cnt_clr   = 1'b1;
            state_nxt = WAIT;
          end else begin
            res_x0    = 1'b1;
            state_nxt = WB;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timeout) begin
          bus_err   = 1'b1;
          res_x0    = 1'b1;
          state_nxt = WB;
        end else if (mem_rvalid) begin
          res_load  = 1'b1;
          state_nxt = WB;
        end else cnt_inc = 1'b1;
      end
      WB: begin
        // EX still holds the finished instruction here; it advances at this edge.
        gprs_waddr_o = res_rd;
        gprs_wdata_o = res_data;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (!rst) begin
      mem_req      = 1'b0;
      stall        = 1'b0;
      misalign     = 1'b0;
      bus_err      = 1'b0;
      gprs_waddr_o = REG_X0;
      gprs_wdata_o = DATA_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lat_addr  <= '0;
      lat_f3    <= '0;
      lat_rd    <= REG_X0;
      lat_rw    <= MEM_READ;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      res_rd    <= REG_X0;
      res_data  <= DATA_ZERO;
    end else begin
      if (start) begin
        lat_addr  <= ex_addr;
        lat_f3    <= ex_funct3;
        lat_rd    <= gprs_waddr_i;
        lat_rw    <= ex_mem_rw;
        lat_wdata <= al_wdata;
        lat_wstrb <= al_wstrb;
      end
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (res_load) begin
        res_rd   <= lat_rd;
        res_data <= al_ld_data;
      end else if (res_x0) begin
        res_rd   <= REG_X0;
        res_data <= DATA_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb (XLEN=32, TIMEOUT=8) with a small memory responder.
module tb_lsu_wb;
  import lsu_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_mem_ena = 1'b0, ex_mem_rw = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0, ex_store_data = '0, gprs_wdata_i = '0;
  logic [4:0]  gprs_waddr_i = '0;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [4:0]  gprs_waddr_o;
  logic [31:0] gprs_wdata_o;
  logic        misalign, bus_err, stall;

  always #5 clk = ~clk;

  lsu_wb #(.XLEN(32), .REG_AW(5), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_ena(ex_mem_ena), .ex_mem_rw(ex_mem_rw),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .gprs_waddr_i(gprs_waddr_i), .gprs_wdata_i(gprs_wdata_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .gprs_waddr_o(gprs_waddr_o), .gprs_wdata_o(gprs_wdata_o),
    .misalign(misalign), .bus_err(bus_err), .stall(stall)
  );

  // Memory responder: ready after rdy_dly waiting cycles, rvalid the cycle after a read handshake.
  int          rdy_dly = 0;
  int          req_cnt = 0;
  logic        rv_en   = 1'b1;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_word = '0;
  assign mem_ready  = mem_req && (req_cnt >= rdy_dly);
  assign mem_rvalid = rd_pend & rv_en;
  assign mem_rdata  = rd_word;
  always @(posedge clk) begin
    req_cnt <= (mem_req && !mem_ready) ? req_cnt + 1 : 0;
    rd_pend <= mem_req & mem_ready & ~mem_we;
  end

  int vecs = 0, errs = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          n_stall, n_mis, n_berr, berr_at;
  logic        req_seen, req_bad, done, first_stall, wb_req, cap_we;
  logic [31:0] cap_addr, cap_wdata, wb_wdata;
  logic [3:0]  cap_wstrb;
  logic [4:0]  wb_waddr;

  // Present one EX instruction and follow it until stall drops (result cycle).
  task automatic run_op(input logic ena, input logic rw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [31:0] alu);
    ex_valid = 1'b1; ex_mem_ena = ena; ex_mem_rw = rw; ex_funct3 = f3;
    ex_addr = addr; ex_store_data = sd; gprs_waddr_i = rd; gprs_wdata_i = alu;
    n_stall = 0; n_mis = 0; n_berr = 0; berr_at = 0;
    req_seen = 1'b0; req_bad = 1'b0; done = 1'b0; first_stall = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) first_stall = stall;
      if (mem_req) begin
        if (!req_seen) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; cap_we = mem_we;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                     mem_wstrb !== cap_wstrb || mem_we !== cap_we) req_bad = 1'b1;
        req_seen = 1'b1;
      end
      if (misalign) n_mis++;
      if (stall) n_stall++;
      if (bus_err) begin n_berr++; berr_at = n_stall; end
      if (!stall) begin
        wb_waddr = gprs_waddr_o; wb_wdata = gprs_wdata_o; wb_req = mem_req;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("op_completes", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_mem_ena = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state, with a legal load presented to prove stall is masked.
    #2;
    ex_valid = 1'b1; ex_mem_ena = ENABLE; ex_mem_rw = MEM_READ; ex_funct3 = LW; ex_addr = 32'h100;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_waddr", gprs_waddr_o, 0);
    chk("rst_wdata", gprs_wdata_o, 0);
    @(negedge clk);
    chk("rst_req_hold", mem_req, 0);
    ex_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    run_op(DISABLE, MEM_READ, 3'b000, 32'h0, 32'h0, 5'd5, 32'h1234);
    chk("alu_waddr", wb_waddr, 5);
    chk("alu_wdata", wb_wdata, 32'h1234);
    chk("alu_stall", n_stall, 0);
    chk("alu_req", req_seen, 0);
    idle();

    // LB at 0x103
    rd_word = 32'h80FF0000;
    run_op(ENABLE, MEM_READ, LB, 32'h103, 32'h0, 5'd7, 32'h0);
    chk("lb_stall", n_stall, 3);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_we", cap_we, 0);
    chk("lb_waddr", wb_waddr, 7);
    chk("lb_wdata", wb_wdata, 32'hFFFFFF80);
    idle();

    // LHU at 0x102 then a back-to-back LH
    rd_word = 32'hBEEF1234;
    run_op(ENABLE, MEM_READ, LHU, 32'h102, 32'h0, 5'd8, 32'h0);
    chk("lhu_wdata", wb_wdata, 32'h0000BEEF);
    chk("lhu_waddr", wb_waddr, 8);
    chk("lhu_wb_noreq", wb_req, 0);
    rd_word = 32'h00008001;
    run_op(ENABLE, MEM_READ, LH, 32'h100, 32'h0, 5'd9, 32'h0);
    chk("b2b_start", first_stall, 1);
    chk("b2b_stall", n_stall, 3);
    chk("lh_wdata", wb_wdata, 32'hFFFF8001);
    idle();

    // SH at 0x102 with ready delayed 3 cycles
    rdy_dly = 3;
    run_op(ENABLE, MEM_WRITE, SH, 32'h102, 32'h0000ABCD, 5'd10, 32'h0);
    chk("sh_stall", n_stall, 5);
    chk("sh_stable", req_bad, 0);
    chk("sh_addr", cap_addr, 32'h100);
    chk("sh_wdata", cap_wdata, 32'hABCD0000);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_we", cap_we, 1);
    chk("sh_waddr", wb_waddr, 0);
    idle();
    rdy_dly = 0;

    // SB at 0x101: minimum store stall
    run_op(ENABLE, MEM_WRITE, SB, 32'h101, 32'h0000005A, 5'd4, 32'h0);
    chk("sb_stall", n_stall, 2);
    chk("sb_wdata", cap_wdata, 32'h00005A00);
    chk("sb_wstrb", cap_wstrb, 4'b0010);
    idle();

    // LBU at 0x101
    rd_word = 32'h0000A500;
    run_op(ENABLE, MEM_READ, LBU, 32'h101, 32'h0, 5'd6, 32'h0);
    chk("lbu_wdata", wb_wdata, 32'h000000A5);
    idle();

    // Misaligned / illegal accesses
    run_op(ENABLE, MEM_READ, LW, 32'h101, 32'h0, 5'd11, 32'h0);
    chk("lw_mis", n_mis, 1);
    chk("lw_mis_stall", n_stall, 0);
    chk("lw_mis_req", req_seen, 0);
    chk("lw_mis_waddr", wb_waddr, 0);
    idle();
    @(negedge clk);
    chk("mis_pulse_end", misalign, 0);
    @(posedge clk); #1;
    run_op(ENABLE, MEM_READ, LD, 32'h100, 32'h0, 5'd11, 32'h0);
    chk("ld32_mis", n_mis, 1);
    chk("ld32_req", req_seen, 0);
    chk("ld32_waddr", wb_waddr, 0);
    idle();
    run_op(ENABLE, MEM_WRITE, 3'b100, 32'h100, 32'h0, 5'd11, 32'h0);
    chk("s1xx_mis", n_mis, 1);
    chk("s1xx_req", req_seen, 0);
    idle();

    // Read data never returns: abort after 8 WAIT cycles
    rv_en = 1'b0;
    run_op(ENABLE, MEM_READ, LW, 32'h100, 32'h0, 5'd12, 32'h0);
    chk("to_berr", n_berr, 1);
    chk("to_berr_at", berr_at, 11);
    chk("to_stall", n_stall, 11);
    chk("to_waddr", wb_waddr, 0);
    idle();
    rv_en = 1'b1;

    // Reset during REQ
    rdy_dly = 100;
    ex_valid = 1'b1; ex_mem_ena = ENABLE; ex_mem_rw = MEM_WRITE; ex_funct3 = SW;
    ex_addr = 32'h100; ex_store_data = 32'h11; gprs_waddr_i = 5'd2;
    @(negedge clk);
    chk("rq_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("rq_rst_req", mem_req, 0);
    chk("rq_rst_stall", stall, 0);
    chk("rq_rst_waddr", gprs_waddr_o, 0);
    ex_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rq_post_req", mem_req, 0);
    chk("rq_post_stall", stall, 0);
    @(posedge clk); #1;
    rdy_dly = 0;

    // Recovery: a plain LW still works
    rd_word = 32'h12345678;
    run_op(ENABLE, MEM_READ, LW, 32'h104, 32'h0, 5'd3, 32'h0);
    chk("rec_addr", cap_addr, 32'h104);
    chk("rec_waddr", wb_waddr, 3);
    chk("rec_wdata", wb_wdata, 32'h12345678);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
